// File: rtl/key_pkg.sv
// Shared types and defaults for the keypoint hit controller: keypoint record,
// controller state encoding and a saturating counter helper.
package key_pkg;

  localparam int unsigned DEF_IMG_W   = 640;
  localparam int unsigned DEF_IMG_H   = 480;
  localparam int unsigned DEF_COL_DLY = 15;
  localparam int unsigned DEF_ROW_DLY = 15;

  typedef struct packed {
    logic [11:0] sin;
    logic [11:0] cos;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  score;
  } keypoint_t;

  localparam int unsigned KEY_W = $bits(keypoint_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2
  } hit_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/key_target_cmp.sv
// Window-complete target of the head keypoint and its relation to the
// current raster position. Purely combinational.
module key_target_cmp #(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned COL_DLY = 15,
  parameter int unsigned ROW_DLY = 15
) (
  input  logic [9:0]  key_x,
  input  logic [9:0]  key_y,
  input  logic [10:0] cx,
  input  logic [10:0] cy,
  output logic        match,
  output logic        stale,
  output logic        outside
);

  logic [10:0] tx_s;
  logic [10:0] ty_s;

  // 11-bit sums cannot overflow for 10-bit coordinates and small delays
  assign tx_s = {1'b0, key_x} + 11'(COL_DLY);
  assign ty_s = {1'b0, key_y} + 11'(ROW_DLY);

  assign match   = (tx_s == cx) && (ty_s == cy);
  assign stale   = (ty_s < cy) || ((ty_s == cy) && (tx_s < cx));
  assign outside = (tx_s >= 11'(IMG_W)) || (ty_s >= 11'(IMG_H));

endmodule

// File: rtl/key_hit_ctrl.sv
// Pops head keypoints from the keypoint buffer when their BRIEF window
// completes in the pixel stream, and drops keypoints that can no longer match.
module key_hit_ctrl
  import key_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned COL_DLY = DEF_COL_DLY,
  parameter int unsigned ROW_DLY = DEF_ROW_DLY
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [11:0] i_key_sin,
  input  logic [11:0] i_key_cos,
  input  logic [9:0]  i_key_coor_x,
  input  logic [9:0]  i_key_coor_y,
  input  logic [7:0]  i_key_score,
  output logic        o_hit,
  output logic        o_valid,
  output logic [11:0] o_sin,
  output logic [11:0] o_cos,
  output logic [9:0]  o_coor_x,
  output logic [9:0]  o_coor_y,
  output logic [7:0]  o_score,
  output logic [15:0] o_drop_cnt,
  output logic        o_frame_done
);

  localparam logic [10:0] LAST_X = 11'(IMG_W - 1);
  localparam logic [10:0] LAST_Y = 11'(IMG_H - 1);

  hit_state_e  state_r;
  hit_state_e  state_nxt_s;
  logic [10:0] cx_r;
  logic [10:0] cy_r;
  logic [10:0] cx_nxt_s;
  logic [10:0] cy_nxt_s;
  logic [10:0] eval_cx_s;
  logic [10:0] eval_cy_s;
  logic        eval_s;
  logic        clear_drop_s;
  logic        flush_drop_s;
  logic        frame_done_s;
  logic        head_valid_s;
  logic        match_s;
  logic        stale_s;
  logic        outside_s;
  logic        capture_s;
  logic        drop_s;
  keypoint_t   head_s;
  keypoint_t   key_r;
  logic        valid_r;
  logic [15:0] drop_cnt_r;

  assign head_s = '{sin: i_key_sin, cos: i_key_cos, x: i_key_coor_x,
                    y: i_key_coor_y, score: i_key_score};
  assign head_valid_s = (i_key_score != 8'd0);

  // the start-of-frame pixel is evaluated as (0,0) while still in IDLE
  assign eval_cx_s = (state_r == ST_IDLE) ? 11'd0 : cx_r;
  assign eval_cy_s = (state_r == ST_IDLE) ? 11'd0 : cy_r;

  key_target_cmp #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .COL_DLY(COL_DLY),
    .ROW_DLY(ROW_DLY)
  ) u_cmp (
    .key_x  (i_key_coor_x),
    .key_y  (i_key_coor_y),
    .cx     (eval_cx_s),
    .cy     (eval_cy_s),
    .match  (match_s),
    .stale  (stale_s),
    .outside(outside_s)
  );

  // next state, pixel evaluation and raster advance
  always_comb begin
    state_nxt_s  = state_r;
    cx_nxt_s     = cx_r;
    cy_nxt_s     = cy_r;
    eval_s       = 1'b0;
    clear_drop_s = 1'b0;
    flush_drop_s = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid && i_sof) begin
          eval_s       = 1'b1;
          clear_drop_s = 1'b1;
          state_nxt_s  = ST_SCAN;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (i_valid) begin
          eval_s = 1'b1;
        end else begin
          eval_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (head_valid_s) begin
          flush_drop_s = 1'b1;
        end else begin
          frame_done_s = 1'b1;
          state_nxt_s  = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (eval_s) begin
      if (eval_cx_s == LAST_X) begin
        cx_nxt_s = 11'd0;
        if (eval_cy_s == LAST_Y) begin
          cy_nxt_s    = 11'd0;
          state_nxt_s = ST_FLUSH;
        end else begin
          cy_nxt_s = eval_cy_s + 11'd1;
        end
      end else begin
        cx_nxt_s = eval_cx_s + 11'd1;
        cy_nxt_s = eval_cy_s;
      end
    end else begin
      cx_nxt_s = cx_r;
      cy_nxt_s = cy_r;
    end
  end

  // an out-of-image target can only leave the buffer as a drop
  assign capture_s = eval_s && head_valid_s && match_s && !outside_s;
  assign drop_s    = (eval_s && head_valid_s && stale_s) || flush_drop_s;

  // state and raster position
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cx_r    <= 11'd0;
      cy_r    <= 11'd0;
    end else begin
      state_r <= state_nxt_s;
      cx_r    <= cx_nxt_s;
      cy_r    <= cy_nxt_s;
    end
  end

  // captured keypoint and its one-cycle valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= capture_s;
      if (capture_s) begin
        key_r <= head_s;
      end else begin
        key_r <= key_r;
      end
    end
  end

  // per-frame saturating drop counter, cleared by the start-of-frame pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_r <= 16'd0;
    end else if (clear_drop_s) begin
      drop_cnt_r <= drop_s ? 16'd1 : 16'd0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc16(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign o_hit        = (capture_s || drop_s) && i_rst_n;
  assign o_valid      = valid_r;
  assign o_sin        = key_r.sin;
  assign o_cos        = key_r.cos;
  assign o_coor_x     = key_r.x;
  assign o_coor_y     = key_r.y;
  assign o_score      = key_r.score;
  assign o_drop_cnt   = drop_cnt_r;
  assign o_frame_done = frame_done_s;

endmodule

// File: tb/tb_key_hit_ctrl.sv
// Self-checking bench for key_hit_ctrl on a reduced image, using a keypoint
// buffer model and a raster-index reference model.
module tb_key_hit_ctrl;
  import key_pkg::*;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int CD = 5;
  localparam int RD = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_sof;
  logic [11:0] i_key_sin, i_key_cos;
  logic [9:0]  i_key_coor_x, i_key_coor_y;
  logic [7:0]  i_key_score;
  logic        o_hit, o_valid, o_frame_done;
  logic [11:0] o_sin, o_cos;
  logic [9:0]  o_coor_x, o_coor_y;
  logic [7:0]  o_score;
  logic [15:0] o_drop_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  keypoint_t   q[$];
  keypoint_t   late_q[$];
  int          late_at;
  logic [9:0]  cap_x[$];

  int          m_state;   // 0 idle, 1 scanning, 2 flushing
  int          m_pos;
  int          m_drop;
  bit          m_valid;
  keypoint_t   m_key;

  key_hit_ctrl #(.IMG_W(W), .IMG_H(H), .COL_DLY(CD), .ROW_DLY(RD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof),
    .i_key_sin(i_key_sin), .i_key_cos(i_key_cos),
    .i_key_coor_x(i_key_coor_x), .i_key_coor_y(i_key_coor_y),
    .i_key_score(i_key_score), .o_hit(o_hit), .o_valid(o_valid),
    .o_sin(o_sin), .o_cos(o_cos), .o_coor_x(o_coor_x), .o_coor_y(o_coor_y),
    .o_score(o_score), .o_drop_cnt(o_drop_cnt), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  function automatic keypoint_t kp(input int x, input int y, input int s);
    keypoint_t k;
    k.sin = 12'($urandom); k.cos = 12'($urandom);
    k.x = 10'(x); k.y = 10'(y); k.score = 8'(s);
    return k;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_drop = 0; m_valid = 1'b0; m_key = '0;
  endtask

  task automatic check_zero_outputs();
    chk("rst_hit", o_hit, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_key", {o_sin, o_cos, o_coor_x, o_coor_y, o_score}, 52'd0);
    chk("rst_drop", o_drop_cnt, 16'd0);
    chk("rst_done", o_frame_done, 1'b0);
  endtask

  // one clock: drive at posedge+1, check at negedge, advance the model after posedge
  task automatic tick(input bit v, input bit s);
    bit e_cap, e_drop, e_done, has, ev;
    int pos, tx, ty, tgt;
    keypoint_t h;
    logic [63:0] r;
    i_valid = v; i_sof = s;
    has = (q.size() > 0);
    if (has) h = q[0];
    else begin r = {$urandom, $urandom}; h = r[51:0]; h.score = 8'd0; end
    i_key_sin = h.sin; i_key_cos = h.cos; i_key_coor_x = h.x;
    i_key_coor_y = h.y; i_key_score = h.score;
    e_cap = 1'b0; e_drop = 1'b0; e_done = 1'b0;
    ev  = v && (m_state == 1 || (m_state == 0 && s));
    pos = (m_state == 0) ? 0 : m_pos;
    if (ev && has) begin
      tx  = int'(h.x) + CD;
      ty  = int'(h.y) + RD;
      tgt = ty * W + ((tx < W) ? tx : W - 1);
      if (tx < W && ty < H && pos == tgt) e_cap = 1'b1;
      else if (pos > tgt) e_drop = 1'b1;
    end
    if (m_state == 2) begin
      if (has) e_drop = 1'b1; else e_done = 1'b1;
    end
    @(negedge clk);
    chk("hit", o_hit, e_cap | e_drop);
    chk("valid", o_valid, m_valid);
    chk("key", {o_sin, o_cos, o_coor_x, o_coor_y, o_score}, m_key);
    chk("drop_cnt", o_drop_cnt, 16'(m_drop));
    chk("frame_done", o_frame_done, e_done);
    if (o_valid) cap_x.push_back(o_coor_x);
    @(posedge clk); #1;
    if (e_cap | e_drop) void'(q.pop_front());
    if (ev && m_state == 0) m_drop = 0;
    if (e_drop && m_drop < 65535) m_drop++;
    m_valid = e_cap;
    if (e_cap) m_key = h;
    if (e_done) m_state = 0;
    else if (ev) begin
      if (pos == W * H - 1) begin m_state = 2; m_pos = 0; end
      else begin m_state = 1; m_pos = pos + 1; end
    end
  endtask

  // mode 0: continuous valid; mode 1: valid every other cycle plus stray sof
  task automatic run_scan(input int mode, input bit rst_mid, input int budget);
    int c;
    bit v, s;
    c = 0;
    tick(1'b1, 1'b1);
    while (m_state != 0 && c < budget) begin
      if (c == late_at) while (late_q.size() > 0) q.push_back(late_q.pop_front());
      v = (mode == 0) ? 1'b1 : (c % 2 == 1);
      s = (mode == 1) && v && ($urandom_range(0, 15) == 0);
      tick(v, s);
      c++;
      if (rst_mid && m_valid) begin
        rst_n = 1'b0; i_valid = 1'b1; i_sof = 1'b1;
        #1;
        check_zero_outputs();
        model_reset();
        @(posedge clk); #1;
        i_sof = 1'b0; rst_n = 1'b1;
        return;
      end
    end
    chk("frame_budget", (c < budget), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_key_sin = 12'd0; i_key_cos = 12'd0; i_key_coor_x = 10'd0;
    i_key_coor_y = 10'd0; i_key_score = 8'd0;
    late_at = -1;
    model_reset();
    #2;
    check_zero_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // frame A: single hit, adjacent pair, late stale push, out-of-image flush drop
    q.push_back(kp(10, 6, 9));
    q.push_back(kp(20, 8, 3));
    q.push_back(kp(21, 8, 4));
    late_q.push_back(kp(1, 2, 5));
    late_q.push_back(kp(30, 20, 6));
    late_q.push_back(kp(35, 27, 7));
    late_at = 600;
    repeat (3) tick(1'b1, 1'b0);
    cap_x.delete();
    run_scan(0, 1'b0, 2000);
    late_at = -1;
    chk("a_drops", o_drop_cnt, 16'd2);
    chk("a_ncap", cap_x.size(), 4);
    if (cap_x.size() == 4) begin
      chk("a_cap0", cap_x[0], 10'd10);
      chk("a_cap1", cap_x[1], 10'd20);
      chk("a_cap2", cap_x[2], 10'd21);
      chk("a_cap3", cap_x[3], 10'd30);
    end
    repeat (2) tick(1'b1, 1'b0);

    // frame B: random keys, gapped valid, stray sof during the scan
    for (int i = 0; i < 8; i++)
      q.push_back(kp($urandom_range(0, 44), $urandom_range(0, 29), $urandom_range(1, 255)));
    run_scan(1, 1'b0, 4000);

    // frame C: reset while a capture is being presented
    q.push_back(kp(10, 6, 9));
    for (int i = 0; i < 4; i++)
      q.push_back(kp($urandom_range(0, 44), $urandom_range(0, 29), $urandom_range(1, 255)));
    run_scan(1, 1'b1, 4000);
    repeat (2) tick(1'b0, 1'b0);

    // frame D: restart after reset with the buffer leftovers plus random keys
    for (int i = 0; i < 6; i++)
      q.push_back(kp($urandom_range(0, 44), $urandom_range(0, 29), $urandom_range(1, 255)));
    run_scan(0, 1'b0, 2000);

    // frame E: one in-image key, buffer empty when the flush starts
    q.push_back(kp(0, 0, 1));
    cap_x.delete();
    run_scan(0, 1'b0, 2000);
    chk("e_drops", o_drop_cnt, 16'd0);
    chk("e_ncap", cap_x.size(), 1);
    tick(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
